lab3_cache_mem_responder: RTL and testbench

//   Memory-side responder for the cache's refill/evict port. Accepts mem_req_4B_t

---
 rtl/lab3_cache_mem_responder.sv | 143 ++++++++++++++
 tb/tb_lab3_cache_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_mem_responder.sv
// Word-addressed memory responder for the cache refill/evict port.
// Fixed-latency pipe feeds an in-order response FIFO, with flow control by credits.
module lab3_cache_mem_responder #(
    parameter int p_num_words   = 256,
    parameter int p_latency     = 2,
    parameter int p_queue_depth = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg
);

    localparam int AW = $clog2(p_num_words);
    localparam int PW = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
    localparam int CW = $clog2(p_queue_depth + 1);
    localparam logic [CW-1:0] FULL_CREDITS = CW'(p_queue_depth);
    localparam logic [PW-1:0] LAST_SLOT = PW'(p_queue_depth - 1);

    logic [2:0]    req_type;
    logic [7:0]    req_opaque;
    logic [AW-1:0] req_idx;
    logic [31:0]   req_data;
    logic          req_writes;
    logic [46:0]   resp_new;
    logic          accept;
    logic          deq;

    logic [31:0]   mem [p_num_words];
    logic [CW-1:0] credits;

    logic          enq_val;
    logic [46:0]   enq_msg;

    logic [46:0]   fifo [p_queue_depth];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          unused_req;

    assign req_type   = memreq_msg[76:74];
    assign req_opaque = memreq_msg[73:66];
    assign req_idx    = memreq_msg[36 +: AW];
    assign req_data   = memreq_msg[31:0];
    assign req_writes = (req_type == 3'd1) || (req_type == 3'd2);

    // Byte offset, len and address bits above the store are don't-cares.
    assign unused_req = ^{memreq_msg[65:36+AW], memreq_msg[35:32]};

    assign resp_new = {req_type, req_opaque, 2'b00, 2'b00,
                       (req_type == 3'd0) ? mem[req_idx] : 32'h0};

    assign memreq_rdy = !reset && (credits != '0);
    assign accept     = memreq_val && memreq_rdy;
    assign deq        = memresp_val && memresp_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_num_words; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && req_writes) begin
            mem[req_idx] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= FULL_CREDITS;
        end else if (accept && !deq) begin
            credits <= credits - 1'b1;
        end else if (!accept && deq) begin
            credits <= credits + 1'b1;
        end
    end

    // The FIFO register is the final latency stage, so the pipe holds one fewer.
    if (p_latency == 1) begin : g_direct
        assign enq_val = accept;
        assign enq_msg = resp_new;
    end else begin : g_pipe
        logic        sr_val [p_latency-1];
        logic [46:0] sr_msg [p_latency-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < p_latency - 1; i++) begin
                    sr_val[i] <= 1'b0;
                end
            end else begin
                sr_val[0] <= accept;
                for (int i = 1; i < p_latency - 1; i++) begin
                    sr_val[i] <= sr_val[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            sr_msg[0] <= resp_new;
            for (int i = 1; i < p_latency - 1; i++) begin
                sr_msg[i] <= sr_msg[i-1];
            end
        end

        assign enq_val = sr_val[p_latency-2];
        assign enq_msg = sr_msg[p_latency-2];
    end

    always_ff @(posedge clk) begin
        if (enq_val) begin
            fifo[wptr] <= enq_msg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (enq_val) begin
                wptr <= (wptr == LAST_SLOT) ? '0 : wptr + 1'b1;
            end
            if (deq) begin
                rptr <= (rptr == LAST_SLOT) ? '0 : rptr + 1'b1;
            end
            if (enq_val && !deq) begin
                count <= count + 1'b1;
            end else if (!enq_val && deq) begin
                count <= count - 1'b1;
            end
        end
    end

    assign memresp_val = (count != '0);
    assign memresp_msg = memresp_val ? fifo[rptr] : '0;

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Directed bench for lab3_cache_mem_responder with default parameters.
// Responses are captured by a monitor queue and checked in order.
module tb_lab3_cache_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [76:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [46:0] memresp_msg;

    int passed = 0;
    int total  = 0;

    logic [46:0] rq [$];
    logic [7:0]  eq [$];

    lab3_cache_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so a negedge view predicts the transfer.
    always @(negedge clk) begin
        if (!reset && memresp_val && memresp_rdy) begin
            rq.push_back(memresp_msg);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [76:0] req(input logic [2:0] t, input logic [7:0] op,
                                        input logic [31:0] a, input logic [31:0] d);
        return {t, op, a, 2'b00, d};
    endfunction

    function automatic logic [46:0] rsp(input logic [2:0] t, input logic [7:0] op,
                                        input logic [31:0] d);
        return {t, op, 4'b0000, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] d);
        memreq_msg = req(t, op, a, d);
        memreq_val = 1'b1;
        for (int n = 0; n < 50 && !memreq_rdy; n++) cyc();
        chk("send_rdy", memreq_rdy, 1);
        cyc();
        memreq_val = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        for (int k = 0; k < 60 && rq.size() < n; k++) cyc();
        chk("resp_count", rq.size(), n);
    endtask

    initial begin
        int acc;
        int stalls;
        logic [7:0] op;

        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b1;
        repeat (3) cyc();
        chk("rst_req_rdy", memreq_rdy, 0);
        chk("rst_resp_val", memresp_val, 0);
        chk("rst_resp_msg", memresp_msg, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_rdy", memreq_rdy, 1);
        cyc();

        // Write then read the same word
        rq.delete();
        send(3'd1, 8'h05, 32'h0000_0040, 32'hDEAD_BEEF);
        send(3'd0, 8'h06, 32'h0000_0040, 32'h0);
        wait_resp(2);
        chk("t1_write_resp", rq[0], rsp(3'd1, 8'h05, 32'h0));
        chk("t1_read_resp", rq[1], rsp(3'd0, 8'h06, 32'hDEAD_BEEF));

        // Latency of a single read
        repeat (2) cyc();
        rq.delete();
        memreq_msg = req(3'd0, 8'h07, 32'h0000_0040, 32'h0);
        memreq_val = 1'b1;
        chk("t2_rdy", memreq_rdy, 1);
        cyc();
        memreq_val = 1'b0;
        chk("t2_val_t1", memresp_val, 0);
        cyc();
        chk("t2_val_t2", memresp_val, 1);
        chk("t2_msg", memresp_msg, rsp(3'd0, 8'h07, 32'hDEAD_BEEF));
        cyc();
        chk("t2_val_t3", memresp_val, 0);
        chk("t2_count", rq.size(), 1);

        // Back-pressure fills all credits
        rq.delete();
        memresp_rdy = 1'b0;
        memreq_val  = 1'b1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            memreq_msg = req(3'd0, 8'(8'h10 + acc), 32'h0000_0040, 32'h0);
            if (memreq_rdy) acc++;
            cyc();
        end
        memreq_val = 1'b0;
        chk("t3_accepts", acc, 4);
        chk("t3_rdy_low", memreq_rdy, 0);
        chk("t3_val_held", memresp_val, 1);
        chk("t3_msg_held", memresp_msg, rsp(3'd0, 8'h10, 32'hDEAD_BEEF));
        memresp_rdy = 1'b1;
        cyc();
        chk("t3_rdy_back", memreq_rdy, 1);
        wait_resp(4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", rq[i], rsp(3'd0, 8'(8'h10 + i), 32'hDEAD_BEEF));
        end

        // Address wrap and unwritten word
        repeat (2) cyc();
        rq.delete();
        send(3'd2, 8'h20, 32'h0000_0400, 32'h0000_1234);
        send(3'd0, 8'h21, 32'h0000_0000, 32'h0);
        send(3'd0, 8'h22, 32'h0000_0080, 32'h0);
        wait_resp(3);
        chk("t4_init_resp", rq[0], rsp(3'd2, 8'h20, 32'h0));
        chk("t4_wrap_read", rq[1], rsp(3'd0, 8'h21, 32'h0000_1234));
        chk("t4_fresh_read", rq[2], rsp(3'd0, 8'h22, 32'h0));

        // Reset with responses outstanding
        repeat (2) cyc();
        rq.delete();
        memresp_rdy = 1'b0;
        send(3'd0, 8'h40, 32'h0000_0040, 32'h0);
        send(3'd0, 8'h41, 32'h0000_0040, 32'h0);
        send(3'd0, 8'h42, 32'h0000_0040, 32'h0);
        repeat (2) cyc();
        chk("t5_pending", memresp_val, 1);
        reset = 1'b1;
        #1;
        chk("t5_val_drop", memresp_val, 0);
        chk("t5_msg_zero", memresp_msg, 0);
        chk("t5_rdy_low", memreq_rdy, 0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("t5_rdy_after", memreq_rdy, 1);
        memresp_rdy = 1'b1;
        rq.delete();
        send(3'd0, 8'h30, 32'h0000_0040, 32'h0);
        wait_resp(1);
        chk("t5_cleared", rq[0], rsp(3'd0, 8'h30, 32'h0));
        repeat (5) cyc();
        chk("t5_no_stale", rq.size(), 1);

        // Full-rate stream with random opaques
        rq.delete();
        memresp_rdy = 1'b1;
        memreq_val  = 1'b1;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            op = 8'($urandom_range(0, 255));
            memreq_msg = req(3'd0, op, 32'h0, 32'h0);
            if (memreq_rdy) eq.push_back(op);
            else stalls++;
            cyc();
        end
        memreq_val = 1'b0;
        chk("t6_stalls", stalls, 0);
        wait_resp(20);
        for (int i = 0; i < 20; i++) begin
            chk("t6_opaque", rq[i], rsp(3'd0, eq[i], 32'h0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
